elevator_fsm: RTL and testbench

Single-car elevator controller. It accepts a requested floor number, moves the car one floor at a time toward it, and reports the car's floor, a motion flag and a travel direction. It sits between the floor-request decode logic and the motor/indicator drivers, and runs in one synchronous clock domain.

---
 rtl/elevator_fsm.sv | 126 ++++++++++++
 tb/tb_elevator_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/elevator_fsm.sv
// Single-car elevator controller: steps the car one floor per FLOOR_CYCLES toward a latched target.
// Optional door dwell after arrival is enabled by defining ELEVATOR_DOOR_DWELL_EN.
module elevator_fsm #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_CYCLES = 1,
  parameter int DOOR_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request_floor,
  output logic [3:0] current_floor,
  output logic       moving,
  output logic       direction
);

  localparam int STEP_W = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FLOOR_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
`ifdef ELEVATOR_DOOR_DWELL_EN
  localparam logic [1:0] S_DOOR = 2'd2;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
`endif

  if (NUM_FLOORS < 1 || NUM_FLOORS > 16 || FLOOR_CYCLES < 1 || DOOR_CYCLES < 1) begin : g_bad_param
    $error("elevator_fsm: illegal parameter value");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        floor_q, floor_d;
  logic [3:0]        target_q, target_d;
  logic              moving_q, moving_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] step_q, step_d;
`ifdef ELEVATOR_DOOR_DWELL_EN
  logic [DOOR_W-1:0] door_q, door_d;
`endif

  logic       req_valid;
  logic [3:0] next_floor;

  // Range check done one bit wider so NUM_FLOORS = 16 compares correctly.
  assign req_valid  = ({1'b0, request_floor} < 5'(NUM_FLOORS)) && (request_floor != floor_q);
  assign next_floor = dir_q ? (floor_q + 4'd1) : (floor_q - 4'd1);

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    target_d = target_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    step_d   = step_q;
`ifdef ELEVATOR_DOOR_DWELL_EN
    door_d   = door_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          target_d = request_floor;
          moving_d = 1'b1;
          dir_d    = (request_floor > floor_q);
          step_d   = '0;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          floor_d = next_floor;
          if (next_floor == target_q) begin
            moving_d = 1'b0;
`ifdef ELEVATOR_DOOR_DWELL_EN
            door_d  = '0;
            state_d = S_DOOR;
`else
            state_d = S_IDLE;
`endif
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
`ifdef ELEVATOR_DOOR_DWELL_EN
      S_DOOR: begin
        if (door_q == DOOR_LAST) begin
          state_d = S_IDLE;
        end else begin
          door_d = door_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      floor_q  <= '0;
      target_q <= '0;
      moving_q <= 1'b0;
      dir_q    <= 1'b0;
      step_q   <= '0;
`ifdef ELEVATOR_DOOR_DWELL_EN
      door_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      target_q <= target_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
`ifdef ELEVATOR_DOOR_DWELL_EN
      door_q   <= door_d;
`endif
    end
  end

  assign current_floor = floor_q;
  assign moving        = moving_q;
  assign direction     = dir_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// Bench for elevator_fsm: two instances (1- and 3-cycle floor travel) against a time-based trip model.
module tb_elevator_fsm;

  localparam int NF = 10;
  localparam int DC = 2;
`ifdef ELEVATOR_DOOR_DWELL_EN
  localparam bit DWELL = 1'b1;
`else
  localparam bit DWELL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] fl_a, fl_b;
  logic       mv_a, mv_b, dr_a, dr_b;

  elevator_fsm #(.NUM_FLOORS(NF), .FLOOR_CYCLES(1), .DOOR_CYCLES(DC)) dut_a (
    .clk(clk), .rst(rst), .request_floor(req),
    .current_floor(fl_a), .moving(mv_a), .direction(dr_a)
  );

  elevator_fsm #(.NUM_FLOORS(NF), .FLOOR_CYCLES(3), .DOOR_CYCLES(DC)) dut_b (
    .clk(clk), .rst(rst), .request_floor(req),
    .current_floor(fl_b), .moving(mv_b), .direction(dr_b)
  );

  always #5 clk = ~clk;

  // Model: a trip is a target plus the cycle number of the next floor change.
  int m_floor[2], m_dir[2], m_mov[2], m_tgt[2], t_next[2], t_ready[2];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int mv_cnt;

  function automatic int fcyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input int q);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_floor[i] = 0; m_mov[i] = 0; m_dir[i] = 0; t_ready[i] = cyc + 1;
      end else if (m_mov[i] != 0) begin
        if (cyc == t_next[i]) begin
          m_floor[i] += (m_dir[i] != 0) ? 1 : -1;
          if (m_floor[i] == m_tgt[i]) begin
            m_mov[i]   = 0;
            t_ready[i] = cyc + 1 + (DWELL ? DC : 0);
          end else begin
            t_next[i] = cyc + fcyc(i);
          end
        end
      end else if (cyc >= t_ready[i] && q < NF && q != m_floor[i]) begin
        m_tgt[i]  = q;
        m_mov[i]  = 1;
        m_dir[i]  = (q > m_floor[i]) ? 1 : 0;
        t_next[i] = cyc + fcyc(i);
      end
    end
  endtask

  task automatic step(input bit r, input int q);
    rst = r;
    req = 4'(q);
    model_edge(r, q);
    @(negedge clk);
    check("a_floor", 32'(fl_a), m_floor[0]);
    check("a_moving", 32'(mv_a), m_mov[0]);
    check("a_dir", 32'(dr_a), m_dir[0]);
    check("b_floor", 32'(fl_b), m_floor[1]);
    check("b_moving", 32'(mv_b), m_mov[1]);
    check("b_dir", 32'(dr_b), m_dir[1]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_floor[i] = 0; m_dir[i] = 0; m_mov[i] = 0; m_tgt[i] = 0; t_next[i] = 0; t_ready[i] = 0;
    end
    @(negedge clk);

    step(1'b1, 0);
    check("rst_floor", 32'(fl_a), 0);
    check("rst_moving", 32'(mv_a), 0);
    check("rst_dir", 32'(dr_a), 0);
    step(1'b0, 0);
    check("idle_moving", 32'(mv_a), 0);

    // Upward trip 0 -> 5
    mv_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 5);
      if (mv_a) mv_cnt++;
    end
    check("up_cycles", 32'(mv_cnt), 5);
    check("up_floor", 32'(fl_a), 5);
    check("up_dir_hold", 32'(dr_a), 1);

    // Downward trip 5 -> 2
    mv_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 2);
      if (mv_a) mv_cnt++;
    end
    check("down_cycles", 32'(mv_cnt), 3);
    check("down_floor", 32'(fl_a), 2);
    check("down_dir_hold", 32'(dr_a), 0);

    // Same floor and out of range requests
    for (int k = 0; k < 3; k++) step(1'b0, 2);
    check("same_moving", 32'(mv_a), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 12);
    check("oor_floor", 32'(fl_a), 2);
    check("oor_moving", 32'(mv_a), 0);

    // Request 9 from floor 2, reset after four floors
    for (int k = 0; k < 5; k++) step(1'b0, 9);
    check("mid_floor", 32'(fl_a), 6);
    step(1'b1, 9);
    check("mid_rst_floor", 32'(fl_a), 0);
    check("mid_rst_moving", 32'(mv_a), 0);
    check("mid_rst_dir", 32'(dr_a), 0);
    step(1'b0, 9);
    check("depart_moving", 32'(mv_a), 1);
    check("depart_dir", 32'(dr_a), 1);
    for (int k = 0; k < 40; k++) step(1'b0, 9);
    check("arrive9_floor", 32'(fl_b), 9);

    // Random requests with occasional reset
    for (int k = 0; k < 150; k++) begin
      int q;
      int hold;
      q    = int'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        step(($urandom_range(0, 59) == 0), q);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
